// File: rtl/nios_dbg_pkg.sv
// Shared constants for the Nios debug OCI RAM arbiter.
//   - sequencer state encoding (IDLE / JTAG read wait / Avalon read wait)
//   - jdo field positions for JTAG address load and JTAG write data
//   - grant-owner encoding used by the round-robin tie-break
package nios_dbg_pkg;

   // Sequencer state encoding
   localparam int unsigned STATE_W = 2;
   typedef logic [STATE_W-1:0] state_t;
   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_RD_WAIT_J = 2'd1;
   localparam state_t ST_RD_WAIT_A = 2'd2;

   // jdo word layout
   localparam int unsigned JDO_W        = 38;
   localparam int unsigned JDO_ADDR_LSB = 17;
   localparam int unsigned JDO_WR_LSB   = 3;
   localparam int unsigned JDO_WR_MSB   = 34;

   // Owner of the most recent grant
   typedef logic owner_t;
   localparam owner_t GNT_JTAG = 1'b0;
   localparam owner_t GNT_AVS  = 1'b1;

endpackage : nios_dbg_pkg

// File: rtl/nios_dbg_jtag_cmd_latch.sv
// JTAG command decode and 1-deep pending slot for the OCI RAM arbiter.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   take_action_ocimem_a          load jtag_addr from jdo
//   take_action_ocimem_b          queue a write of jdo data at jtag_addr
//   take_no_action_ocimem_a       queue a read at jtag_addr
//   jdo                           JTAG data-out word
//   slot_grant                    arbiter consumes the slot this cycle
//   slot_valid/is_wr/addr/data    pending command presented to the arbiter
//   jtag_overrun                  sticky flag, a command was dropped
module nios_dbg_jtag_cmd_latch
   import nios_dbg_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              slot_grant,
   output logic              slot_valid,
   output logic              slot_is_wr,
   output logic [ADDR_W-1:0] slot_addr,
   output logic [DATA_W-1:0] slot_data,
   output logic              jtag_overrun
);

   logic [ADDR_W-1:0] jtag_addr;
   logic              cmd_load;
   logic              cmd_wr;
   logic              cmd_rd;
   logic              prio_drop;
   logic              slot_free;
   logic              capture;
   logic              busy_drop;
   logic              unused_jdo;

   // Bits of jdo outside the address and write-data fields carry nothing here
   assign unused_jdo = ^{jdo[JDO_W-1:JDO_WR_MSB+1], jdo[JDO_WR_LSB-1:0]};

   // Fixed-priority decode: ocimem_a > ocimem_b > no_action_ocimem_a
   always_comb begin
      cmd_load  = take_action_ocimem_a;
      cmd_wr    = take_action_ocimem_b & ~take_action_ocimem_a;
      cmd_rd    = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
      prio_drop = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                | (take_action_ocimem_b & take_no_action_ocimem_a);
      // A slot being granted this cycle can be refilled in the same cycle
      slot_free = ~slot_valid | slot_grant;
      capture   = (cmd_wr | cmd_rd) & slot_free;
      busy_drop = (cmd_wr | cmd_rd) & ~slot_free;
   end

   // Pending slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_valid <= 1'b0;
         slot_is_wr <= 1'b0;
         slot_addr  <= '0;
         slot_data  <= '0;
      end else if (capture) begin
         slot_valid <= 1'b1;
         slot_is_wr <= cmd_wr;
         slot_addr  <= jtag_addr;
         slot_data  <= cmd_wr ? DATA_W'(jdo[JDO_WR_MSB:JDO_WR_LSB]) : '0;
      end else if (slot_grant) begin
         slot_valid <= 1'b0;
      end
   end

   // Auto-incrementing JTAG address; wraps naturally at 2^ADDR_W
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jtag_addr <= '0;
      end else if (cmd_load) begin
         jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if (capture) begin
         jtag_addr <= jtag_addr + ADDR_W'(1);
      end
   end

   // Sticky overrun on any dropped command
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jtag_overrun <= 1'b0;
      end else if (prio_drop | busy_drop) begin
         jtag_overrun <= 1'b1;
      end
   end

endmodule : nios_dbg_jtag_cmd_latch

// File: rtl/nios_dbg_ocimem_arbiter.sv
// Arbiter/sequencer sharing the single-port OCI RAM (1-cycle read latency)
// between the JTAG debug path and the CPU Avalon-MM debug slave.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   take_action_ocimem_a/_b,
//   take_no_action_ocimem_a, jdo      JTAG command pulses and data word
//   MonDReg, jtag_rd_done             JTAG read data and its update pulse
//   jtag_overrun                      sticky, a JTAG command was dropped
//   avs_*                             Avalon-MM slave (waitrequest, 2-cycle read latency)
//   ram_address/wren/wrdata/rddata    OCI RAM port
module nios_dbg_ocimem_arbiter
   import nios_dbg_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [JDO_W-1:0]  jdo,
   output logic [DATA_W-1:0] MonDReg,
   output logic              jtag_rd_done,
   output logic              jtag_overrun,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   output logic              avs_waitrequest,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_wrdata,
   input  logic [DATA_W-1:0] ram_rddata
);

   state_t            state;
   state_t            state_nxt;
   owner_t            last_grant;
   owner_t            last_grant_nxt;
   logic              jtag_req;
   logic              avs_req;
   logic              jtag_grant;
   logic              avs_grant;
   logic              slot_valid;
   logic              slot_is_wr;
   logic [ADDR_W-1:0] slot_addr;
   logic [DATA_W-1:0] slot_data;

   nios_dbg_jtag_cmd_latch #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmd (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .jdo                     (jdo),
      .slot_grant              (jtag_grant),
      .slot_valid              (slot_valid),
      .slot_is_wr              (slot_is_wr),
      .slot_addr               (slot_addr),
      .slot_data               (slot_data),
      .jtag_overrun            (jtag_overrun)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         last_grant <= GNT_AVS;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Next state and grant; on a tie the requester not granted last time wins
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      jtag_grant     = 1'b0;
      avs_grant      = 1'b0;
      jtag_req       = slot_valid;
      avs_req        = avs_read | avs_write;
      case (state)
         ST_IDLE: begin
            if (jtag_req && (!avs_req || (last_grant == GNT_AVS))) begin
               jtag_grant = 1'b1;
            end else if (avs_req) begin
               avs_grant = 1'b1;
            end
            // Nothing may be granted while reset is held
            if (!reset_n) begin
               jtag_grant = 1'b0;
               avs_grant  = 1'b0;
            end
            if (jtag_grant) begin
               last_grant_nxt = GNT_JTAG;
               if (!slot_is_wr) begin
                  state_nxt = ST_RD_WAIT_J;
               end
            end
            if (avs_grant) begin
               last_grant_nxt = GNT_AVS;
               if (avs_read) begin
                  state_nxt = ST_RD_WAIT_A;
               end
            end
         end
         ST_RD_WAIT_J: state_nxt = ST_IDLE;
         ST_RD_WAIT_A: state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   assign avs_waitrequest = (avs_read | avs_write) & ~avs_grant;

   // RAM port mux; idle value is all zeros
   always_comb begin
      ram_address = '0;
      ram_wren    = 1'b0;
      ram_wrdata  = '0;
      if (jtag_grant) begin
         ram_address = slot_addr;
         ram_wren    = slot_is_wr;
         ram_wrdata  = slot_is_wr ? slot_data : '0;
      end else if (avs_grant) begin
         ram_address = avs_address;
         ram_wren    = avs_write;
         ram_wrdata  = avs_write ? avs_writedata : '0;
      end
   end

   // Read return: RAM data is valid in the wait state, registered at its end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         MonDReg           <= '0;
         jtag_rd_done      <= 1'b0;
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
      end else begin
         jtag_rd_done      <= (state == ST_RD_WAIT_J);
         avs_readdatavalid <= (state == ST_RD_WAIT_A);
         if (state == ST_RD_WAIT_J) begin
            MonDReg <= ram_rddata;
         end
         if (state == ST_RD_WAIT_A) begin
            avs_readdata <= ram_rddata;
         end
      end
   end

endmodule : nios_dbg_ocimem_arbiter

// File: tb/tb_nios_dbg_ocimem_arbiter.sv
// Self-checking bench for nios_dbg_ocimem_arbiter: bench-side RAM, a reference
// memory image updated in program order, and per-scenario tasks.
module tb_nios_dbg_ocimem_arbiter;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 256;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              take_action_ocimem_a;
   logic              take_action_ocimem_b;
   logic              take_no_action_ocimem_a;
   logic [37:0]       jdo;
   logic [DATA_W-1:0] MonDReg;
   logic              jtag_rd_done;
   logic              jtag_overrun;
   logic [ADDR_W-1:0] avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [DATA_W-1:0] avs_writedata;
   logic              avs_waitrequest;
   logic [DATA_W-1:0] avs_readdata;
   logic              avs_readdatavalid;
   logic [ADDR_W-1:0] ram_address;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_wrdata;
   logic [DATA_W-1:0] ram_rddata;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DATA_W-1:0] ram_mem [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic              mem_init_req = 1'b0;

   always #5 clk = ~clk;

   nios_dbg_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .jdo                     (jdo),
      .MonDReg                 (MonDReg),
      .jtag_rd_done            (jtag_rd_done),
      .jtag_overrun            (jtag_overrun),
      .avs_address             (avs_address),
      .avs_read                (avs_read),
      .avs_write               (avs_write),
      .avs_writedata           (avs_writedata),
      .avs_waitrequest         (avs_waitrequest),
      .avs_readdata            (avs_readdata),
      .avs_readdatavalid       (avs_readdatavalid),
      .ram_address             (ram_address),
      .ram_wren                (ram_wren),
      .ram_wrdata              (ram_wrdata),
      .ram_rddata              (ram_rddata)
   );

   function automatic logic [DATA_W-1:0] init_word(input int i);
      return {8'(i), 8'(~i), 16'hA5C3 ^ 16'(i * 37)};
   endfunction

   // Single-port RAM with 1-cycle read latency
   always @(posedge clk) begin
      if (mem_init_req) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
      end else begin
         if (ram_wren) ram_mem[ram_address] <= ram_wrdata;
      end
      ram_rddata <= ram_mem[ram_address];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      jdo                     = '0;
      avs_address             = '0;
      avs_read                = 1'b0;
      avs_write               = 1'b0;
      avs_writedata           = '0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   function automatic logic [37:0] jdo_addr(input logic [7:0] a);
      logic [37:0] j;
      j = {6'($urandom), 32'($urandom)};
      j[24:17] = a;
      return j;
   endfunction

   function automatic logic [37:0] jdo_wr(input logic [31:0] d);
      logic [37:0] j;
      j = {6'($urandom), 32'($urandom)};
      j[34:3] = d;
      return j;
   endfunction

   task automatic jtag_load(input logic [7:0] a);
      take_action_ocimem_a = 1'b1;
      jdo = jdo_addr(a);
      step();
      take_action_ocimem_a = 1'b0;
   endtask

   // Write pulse; returns the RAM port as seen in the cycle after the pulse
   task automatic jtag_write(input logic [31:0] d, output logic wren, output logic [7:0] a,
                             output logic [31:0] wd);
      take_action_ocimem_b = 1'b1;
      jdo = jdo_wr(d);
      step();
      take_action_ocimem_b = 1'b0;
      @(negedge clk);
      wren = ram_wren;
      a    = ram_address;
      wd   = ram_wrdata;
      repeat (3) step();
   endtask

   // Read pulse; lat = cycles from pulse to jtag_rd_done, -1 if never seen
   task automatic jtag_read(output logic [31:0] d, output int lat);
      take_no_action_ocimem_a = 1'b1;
      jdo = {6'($urandom), 32'($urandom)};
      step();
      take_no_action_ocimem_a = 1'b0;
      lat = -1;
      d   = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (jtag_rd_done === 1'b1) begin
            lat = c;
            d   = MonDReg;
            step();
            break;
         end
         step();
      end
   endtask

   // Avalon master transfer; waits = stall cycles (-1 on timeout), rlat = grant-to-valid cycles
   task automatic avs_do(input logic is_wr, input logic [7:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int waits, output int rlat);
      logic granted;
      avs_address   = a;
      avs_writedata = wd;
      avs_read      = !is_wr;
      avs_write     = is_wr;
      waits   = 0;
      granted = 1'b0;
      rd      = '0;
      for (int c = 0; c < 20 && !granted; c++) begin
         @(negedge clk);
         if (avs_waitrequest === 1'b0) granted = 1'b1;
         else waits++;
         step();
      end
      avs_read  = 1'b0;
      avs_write = 1'b0;
      if (!granted) waits = -1;
      rlat = 0;
      if (!is_wr && granted) begin
         rlat = -1;
         for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (avs_readdatavalid === 1'b1) begin
               rlat = c;
               rd   = avs_readdata;
               step();
               break;
            end
            step();
         end
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      reset_n      = 1'b0;
      mem_init_req = 1'b1;
      avs_read     = 1'b1;
      avs_address  = 8'h33;
      step();
      mem_init_req = 1'b0;
      step();
      @(negedge clk);
      tests_run++;
      if ({MonDReg, avs_readdata} !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_data: MonDReg=%h avs_readdata=%h want 0", MonDReg, avs_readdata);
      end
      tests_run++;
      if ({jtag_overrun, jtag_rd_done, avs_readdatavalid} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags: ovr/rd_done/rdv=%b%b%b want 000", jtag_overrun, jtag_rd_done, avs_readdatavalid);
      end
      tests_run++;
      if (avs_waitrequest !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_waitrequest: got %b want 1", avs_waitrequest);
      end
      tests_run++;
      if ({ram_address, ram_wren, ram_wrdata} !== 41'h0) begin
         tests_failed++;
         $display("FAIL reset_ram: addr=%h wren=%b wd=%h want 0", ram_address, ram_wren, ram_wrdata);
      end
      step();
      reset_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (avs_waitrequest !== 1'b0 || ram_address !== 8'h33) begin
         tests_failed++;
         $display("FAIL reset_first_grant: waitreq=%b addr=%h want 0/33", avs_waitrequest, ram_address);
      end
      step();
      avs_read = 1'b0;
      @(negedge clk);
      tests_run++;
      if (avs_readdatavalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_rdv_early: got %b want 0", avs_readdatavalid);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (avs_readdatavalid !== 1'b1 || avs_readdata !== ref_mem[8'h33]) begin
         tests_failed++;
         $display("FAIL reset_read_return: rdv=%b data=%h want 1/%h", avs_readdatavalid, avs_readdata, ref_mem[8'h33]);
      end
      step();
   endtask

   task automatic test_autoinc_wrap();
      logic        wren;
      logic [7:0]  a;
      logic [31:0] wd;
      logic [31:0] rd;
      int          lat;
      logic [31:0] wdat [2];
      wdat[0] = 32'hAAAA5555;
      wdat[1] = 32'h12345678;
      jtag_load(8'hFE);
      for (int k = 0; k < 2; k++) begin
         jtag_write(wdat[k], wren, a, wd);
         ref_mem[8'(8'hFE + k)] = wdat[k];
         tests_run++;
         if (wren !== 1'b1 || a !== 8'(8'hFE + k) || wd !== wdat[k]) begin
            tests_failed++;
            $display("FAIL autoinc_write%0d: wren=%b addr=%h data=%h want 1/%h/%h", k, wren, a, wd, 8'(8'hFE + k), wdat[k]);
         end
      end
      jtag_load(8'hFE);
      for (int k = 0; k < 3; k++) begin
         jtag_read(rd, lat);
         tests_run++;
         if (lat != 3 || rd !== ref_mem[8'(8'hFE + k)]) begin
            tests_failed++;
            $display("FAIL autoinc_read%0d: lat=%0d data=%h want 3/%h", k, lat, rd, ref_mem[8'(8'hFE + k)]);
         end
      end
   endtask

   task automatic test_tie();
      logic [31:0] d;
      apply_reset();
      d = $urandom;
      take_action_ocimem_b = 1'b1;
      jdo = jdo_wr(d);
      step();
      take_action_ocimem_b = 1'b0;
      avs_read    = 1'b1;
      avs_address = 8'h10;
      ref_mem[0]  = d;
      @(negedge clk);
      tests_run++;
      if (ram_wren !== 1'b1 || ram_address !== 8'h00 || ram_wrdata !== d || avs_waitrequest !== 1'b1) begin
         tests_failed++;
         $display("FAIL tie_jtag_first: wren=%b addr=%h wd=%h waitreq=%b want 1/00/%h/1", ram_wren, ram_address, ram_wrdata, avs_waitrequest, d);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (avs_waitrequest !== 1'b0 || ram_address !== 8'h10 || ram_wren !== 1'b0) begin
         tests_failed++;
         $display("FAIL tie_avs_next: waitreq=%b addr=%h wren=%b want 0/10/0", avs_waitrequest, ram_address, ram_wren);
      end
      step();
      avs_read = 1'b0;
      @(negedge clk);
      tests_run++;
      if (avs_readdatavalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL tie_rdv_early: got %b want 0", avs_readdatavalid);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (avs_readdatavalid !== 1'b1 || avs_readdata !== ref_mem[8'h10]) begin
         tests_failed++;
         $display("FAIL tie_read_return: rdv=%b data=%h want 1/%h", avs_readdatavalid, avs_readdata, ref_mem[8'h10]);
      end
      step();
   endtask

   task automatic test_contention();
      logic [31:0] dj [9];
      logic [31:0] w;
      logic [7:0]  ea;
      logic [31:0] ed;
      int          idx;
      apply_reset();
      jtag_load(8'h40);
      for (int k = 0; k < 9; k++) dj[k] = $urandom;
      w = $urandom;
      avs_write     = 1'b1;
      avs_address   = 8'h90;
      avs_writedata = w;
      for (int k = 0; k < 8; k++) begin
         take_action_ocimem_b = 1'b1;
         jdo = jdo_wr(dj[k]);
         @(negedge clk);
         // Cycle 0 AVS alone; afterwards JTAG on odd cycles, AVS on even
         if (k % 2 == 0) begin
            ea = 8'h90;
            ed = w;
         end else begin
            idx = (k == 1) ? 0 : k - 2;
            ea  = 8'(8'h40 + (k - 1) / 2);
            ed  = dj[idx];
         end
         tests_run++;
         if (ram_wren !== 1'b1 || ram_address !== ea || ram_wrdata !== ed) begin
            tests_failed++;
            $display("FAIL contention_grant_c%0d: wren=%b addr=%h wd=%h want 1/%h/%h", k, ram_wren, ram_address, ram_wrdata, ea, ed);
         end
         tests_run++;
         if (jtag_overrun !== (k >= 3)) begin
            tests_failed++;
            $display("FAIL contention_overrun_c%0d: got %b want %b", k, jtag_overrun, (k >= 3));
         end
         step();
      end
      take_action_ocimem_b = 1'b0;
      avs_write = 1'b0;
      @(negedge clk);
      tests_run++;
      if (ram_wren !== 1'b1 || ram_address !== 8'h44 || ram_wrdata !== dj[7]) begin
         tests_failed++;
         $display("FAIL contention_drain: wren=%b addr=%h wd=%h want 1/44/%h", ram_wren, ram_address, ram_wrdata, dj[7]);
      end
      ref_mem[8'h90] = w;
      ref_mem[8'h40] = dj[0];
      ref_mem[8'h41] = dj[1];
      ref_mem[8'h42] = dj[3];
      ref_mem[8'h43] = dj[5];
      ref_mem[8'h44] = dj[7];
      repeat (2) step();
   endtask

   task automatic test_load_write_collision();
      logic [37:0] j;
      logic [31:0] rd;
      int          lat;
      int          wr_seen;
      apply_reset();
      j = jdo_wr($urandom);
      j[24:17] = 8'h5A;
      take_action_ocimem_a = 1'b1;
      take_action_ocimem_b = 1'b1;
      jdo = j;
      step();
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      wr_seen = 0;
      @(negedge clk);
      tests_run++;
      if (jtag_overrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL collision_overrun: got %b want 1", jtag_overrun);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (ram_wren === 1'b1) wr_seen++;
         step();
      end
      tests_run++;
      if (wr_seen != 0) begin
         tests_failed++;
         $display("FAIL collision_no_write: saw %0d RAM writes want 0", wr_seen);
      end
      jtag_read(rd, lat);
      tests_run++;
      if (lat != 3 || rd !== ref_mem[8'h5A]) begin
         tests_failed++;
         $display("FAIL collision_addr_loaded: lat=%0d data=%h want 3/%h", lat, rd, ref_mem[8'h5A]);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] rd;
      int          lat;
      int          waits;
      int          rlat;
      int          done_seen;
      apply_reset();
      jtag_read(rd, lat);
      jtag_load(8'h77);
      take_no_action_ocimem_a = 1'b1;
      step();
      take_no_action_ocimem_a = 1'b0;
      step();
      reset_n = 1'b0;
      @(negedge clk);
      tests_run++;
      if (jtag_rd_done !== 1'b0 || MonDReg !== 32'h0) begin
         tests_failed++;
         $display("FAIL midread_reset: rd_done=%b MonDReg=%h want 0/0", jtag_rd_done, MonDReg);
      end
      step();
      step();
      reset_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (jtag_rd_done === 1'b1) done_seen++;
         step();
      end
      tests_run++;
      if (done_seen != 0 || MonDReg !== 32'h0) begin
         tests_failed++;
         $display("FAIL midread_no_done: rd_done pulses=%0d MonDReg=%h want 0/0", done_seen, MonDReg);
      end
      avs_do(1'b0, 8'h77, 32'h0, rd, waits, rlat);
      tests_run++;
      if (waits != 0 || rlat != 2 || rd !== ref_mem[8'h77]) begin
         tests_failed++;
         $display("FAIL midread_idle_after: waits=%0d rlat=%0d data=%h want 0/2/%h", waits, rlat, rd, ref_mem[8'h77]);
      end
   endtask

   task automatic test_random();
      int jtag_fail = 0;
      int avs_fail  = 0;
      apply_reset();
      fork
         begin : jtag_stream
            logic [7:0]  ptr;
            logic [31:0] d;
            logic [31:0] rd;
            logic        wren;
            logic [7:0]  a;
            logic [31:0] wd;
            int          lat;
            for (int b = 0; b < 6; b++) begin
               ptr = 8'($urandom_range(0, 8'h70));
               jtag_load(ptr);
               for (int n = 0; n < 8; n++) begin
                  if ($urandom_range(0, 1) == 1) begin
                     d = $urandom;
                     jtag_write(d, wren, a, wd);
                     ref_mem[ptr] = d;
                  end else begin
                     jtag_read(rd, lat);
                     tests_run++;
                     if (lat < 3 || lat > 5 || rd !== ref_mem[ptr]) begin
                        tests_failed++;
                        jtag_fail++;
                        $display("FAIL random_jtag_read @%h: lat=%0d data=%h want 3..5/%h", ptr, lat, rd, ref_mem[ptr]);
                     end
                  end
                  ptr = ptr + 8'd1;
               end
            end
         end
         begin : avs_stream
            logic [7:0]  a;
            logic [31:0] wd;
            logic [31:0] rd;
            logic        is_wr;
            int          waits;
            int          rlat;
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(0, 2)) step();
               a     = 8'($urandom_range(8'h80, 8'hFF));
               wd    = $urandom;
               is_wr = 1'($urandom_range(0, 1));
               avs_do(is_wr, a, wd, rd, waits, rlat);
               if (is_wr) ref_mem[a] = wd;
               tests_run++;
               if (waits < 0 || waits > 2) begin
                  tests_failed++;
                  avs_fail++;
                  $display("FAIL random_avs_wait @%h: waits=%0d want 0..2", a, waits);
               end
               if (!is_wr) begin
                  tests_run++;
                  if (rlat != 2 || rd !== ref_mem[a]) begin
                     tests_failed++;
                     avs_fail++;
                     $display("FAIL random_avs_read @%h: rlat=%0d data=%h want 2/%h", a, rlat, rd, ref_mem[a]);
                  end
               end
            end
         end
      join
      tests_run++;
      if (jtag_overrun !== 1'b0) begin
         tests_failed++;
         $display("FAIL random_overrun: got %b want 0 (jtag errs %0d, avs errs %0d)", jtag_overrun, jtag_fail, avs_fail);
      end
   endtask

   task automatic test_mem_image();
      int bad = 0;
      int first_bad = -1;
      repeat (3) step();
      for (int i = 0; i < DEPTH; i++) begin
         if (ram_mem[i] !== ref_mem[i]) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL mem_image: %0d words differ, first at %0d (got %h want %h)", bad, first_bad,
                  ram_mem[first_bad], ref_mem[first_bad]);
      end
   endtask

   initial begin
      test_reset();
      test_autoinc_wrap();
      test_tie();
      test_contention();
      test_load_write_collision();
      test_reset_mid_read();
      test_random();
      test_mem_image();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_nios_dbg_ocimem_arbiter

// File: doc/nios_dbg_ocimem_arbiter.md
# nios_dbg_ocimem_arbiter

Sysclk-domain arbiter and sequencer for the Nios debug on-chip memory (OCI RAM, single port, 1-cycle read latency). It shares the RAM between the JTAG debug path and the CPU's Avalon-MM debug memory slave. The JTAG path is driven by the synchronized `take_action_*` pulses and `jdo` from the debug-slave sysclk block. JTAG accesses use an auto-incrementing address register, and JTAG read data is returned on `MonDReg`.

## Interface
- `ADDR_W`, 8, RAM word-address width
- `DATA_W`, 32, RAM data width; fixed at 32 because `jdo` packing assumes it
- `clk`  in  1  system clock; one clock for the whole block
- `reset_n`  in  1  asynchronous, active-low reset
- `take_action_ocimem_a`  in  1  pulse: load JTAG address from `jdo[ADDR_W+16:17]`
- `take_action_ocimem_b`  in  1  pulse: JTAG write of `jdo[34:3]` at the JTAG address, then increment the address
- `take_no_action_ocimem_a`  in  1  pulse: JTAG read at the JTAG address, then increment the address
- `jdo`  in  38  JTAG data-out word
- `MonDReg`  out  32  last JTAG read data
- `jtag_rd_done`  out  1  1-cycle pulse, asserted in the same cycle `MonDReg` updates
- `jtag_overrun`  out  1  sticky; a JTAG command was dropped
- `avs_address`  in  ADDR_W  CPU word address
- `avs_read`, `avs_write`  in  1  CPU request strobes; never asserted together
- `avs_writedata`  in  32  CPU write data
- `avs_waitrequest`  out  1  `(avs_read|avs_write) & ~avs_grant`
- `avs_readdata`  out  32  CPU read data
- `avs_readdatavalid`  out  1  1-cycle pulse
- `ram_address`  out  ADDR_W  RAM address
- `ram_wren`  out  1  RAM write enable
- `ram_wrdata`  out  32  RAM write data
- `ram_rddata`  in  32  RAM read data, valid 1 cycle after the address is presented

## Operation
- JTAG command decode:
  - Priority within a cycle is `ocimem_a` > `ocimem_b` > `no_action_ocimem_a`.
  - Any lower-priority pulse in the same cycle is dropped and sets `jtag_overrun`.
- Address load (`ocimem_a`):
  - Updates `jtag_addr` at the clock edge.
  - Never needs the RAM and never stalls.
- Pending slot for `ocimem_b` / `no_action`:
  - The command is latched into a 1-deep slot `{valid, is_wr, addr, data}`, with `addr = jtag_addr` at capture.
  - `jtag_addr` increments at capture and wraps from `2^ADDR_W-1` to 0.
  - A new command arriving while the slot is valid and not being granted that cycle is dropped and sets `jtag_overrun`.
  - A slot being granted in a cycle may be reloaded in the same cycle.
- FSM states:
  - IDLE: grants at most one requester.
  - RD_WAIT_J: JTAG read in flight; no grant.
  - RD_WAIT_A: Avalon read in flight; no grant.
- IDLE behaviour:
  - If only one requester is present, it is granted.
  - If both are present, the one not named by `last_grant` wins (round-robin).
- Grant behaviour:
  - The granted requester drives `ram_address` (and `ram_wren`/`ram_wrdata` for a write) combinationally in the grant cycle.
  - A write returns to IDLE.
  - A read goes to RD_WAIT_J or RD_WAIT_A.
  - `last_grant` updates on every grant.
- RD_WAIT_J: `MonDReg <= ram_rddata`, pulse `jtag_rd_done`, return to IDLE.
- RD_WAIT_A: `avs_readdata <= ram_rddata`, pulse `avs_readdatavalid`, return to IDLE.
- RAM outputs are 0 when nothing is granted.

## Timing
- Reset values:
  - Registers: state IDLE, slot invalid, `jtag_addr`=0, `last_grant`=AVS (so JTAG wins the first tie).
  - Outputs: `MonDReg`=0, `avs_readdata`=0, `jtag_overrun`=0, `jtag_rd_done`=0, `avs_readdatavalid`=0.
  - While `reset_n` is low, `avs_grant`=0.
- JTAG read latency, for a pulse in cycle t with no contention:
  - t+1: slot valid, granted.
  - t+2: RD_WAIT_J.
  - t+3: `MonDReg` visible and `jtag_rd_done` high.
- JTAG write: RAM write occurs in cycle t+1.
- Avalon write: completes in the grant cycle (`avs_waitrequest`=0 that cycle).
- Avalon read: `avs_readdatavalid` is asserted 2 cycles after the grant cycle.
- Maximum throughput is one write per cycle, or one read per 2 cycles.
- Contention: the loser's wait is at most 2 cycles.
- Reset mid-read: the in-flight read is discarded, with no `readdatavalid` or `jtag_rd_done`; the RAM contents are untouched.

## Structure
- Package `nios_dbg_pkg` holds:
  - the state enum;
  - the `jdo` field constants: address LSB 17, write-data LSB 3, write-data MSB 34;
  - the grant-owner encoding.
- Sub-module `nios_dbg_jtag_cmd_latch` holds the decode, pending slot, `jtag_addr` and overrun logic.
- The top level holds the FSM, arbitration and RAM mux.

## Test plan
- Reset with `avs_read`=1 → all outputs 0, `avs_waitrequest`=1; after release, grant occurs in cycle 1.
- Auto-increment and wrap:
  - Stimulus: load 0xFE; write 0xAAAA5555 then 0x12345678; load 0xFE; read twice.
  - Required: `MonDReg` shows 0xAAAA5555 then 0x12345678; `jtag_addr` ends at 0x00.
- Tie after reset: JTAG write pulse plus `avs_read` of 0x10 in the same cycle →
  - JTAG granted first; `avs_waitrequest`=1 for 1 cycle;
  - Avalon read granted next; `avs_readdatavalid` 2 cycles later.
- Sustained contention:
  - Stimulus: `avs_write` held high while a JTAG write pulse is issued every cycle.
  - Required: grants alternate JTAG/AVS, and `jtag_overrun` sets on the first dropped pulse.
- Simultaneous `ocimem_a` and `ocimem_b` pulses → address loads, write dropped, `jtag_overrun`=1.
- `reset_n` asserted in RD_WAIT_J → no `jtag_rd_done`, `MonDReg`=0, state IDLE.
